// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator and output stage.
// Owns the x/y raster counters, publishes coordinates to the renderer, and
// registers blank-masked colour plus sync, delay-matched to the renderer latency.
// Optional colour-bar test pattern: define VGA_TIMING_TESTPAT_EN to add test_en.
module vga_timing_gen #(
  parameter int unsigned CW   = 1,
  parameter int unsigned XW   = 10,
  parameter int unsigned YW   = 10,
  parameter int unsigned HD   = 640,
  parameter int unsigned HFP  = 16,
  parameter int unsigned HS   = 96,
  parameter int unsigned HBP  = 48,
  parameter int unsigned VD   = 480,
  parameter int unsigned VFP  = 10,
  parameter int unsigned VS   = 2,
  parameter int unsigned VBP  = 33,
  parameter bit          HPOL = 1'b0,
  parameter bit          VPOL = 1'b0,
  parameter int unsigned LAT  = 1
) (
  input  logic            vclk,
  input  logic            reset,
`ifdef VGA_TIMING_TESTPAT_EN
  input  logic            test_en,
`endif
  input  logic [3*CW-1:0] rgb_in,
  output logic [XW-1:0]   posx,
  output logic [YW-1:0]   posy,
  output logic            active,
  output logic            line_start,
  output logic            frame_start,
  output logic [7:0]      frame_cnt,
  output logic            hsync,
  output logic            vsync,
  output logic [CW-1:0]   red,
  output logic [CW-1:0]   green,
  output logic [CW-1:0]   blue
);

  localparam int unsigned HT    = HD + HFP + HS + HBP;
  localparam int unsigned VT    = VD + VFP + VS + VBP;
  localparam int unsigned HsOn  = HD + HFP;
  localparam int unsigned HsOff = HD + HFP + HS;
  localparam int unsigned VsOn  = VD + VFP;
  localparam int unsigned VsOff = VD + VFP + VS;
  localparam logic [XW-1:0] XMax = XW'(HT - 1);
  localparam logic [YW-1:0] YMax = YW'(VT - 1);

  // Pipeline word: {bar[2:0],} active, vsync_raw, hsync_raw
`ifdef VGA_TIMING_TESTPAT_EN
  localparam int unsigned PW = 6;
`else
  localparam int unsigned PW = 3;
`endif

  if (64'(HT) > (64'd1 << XW)) begin : g_xw_err
    $error("vga_timing_gen: HT-1 does not fit in XW bits");
  end
  if (64'(VT) > (64'd1 << YW)) begin : g_yw_err
    $error("vga_timing_gen: VT-1 does not fit in YW bits");
  end
  if (LAT > 15) begin : g_lat_err
    $error("vga_timing_gen: LAT must be 0..15");
  end

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [7:0]    frame_q, frame_d;
  logic          x_wrap, y_wrap;
  logic [31:0]   x32, y32;
  logic          hs_raw, vs_raw;
  logic [PW-1:0] raw, dly;

  // Raster counter next-state: x wraps at HT-1, y advances on x wrap
  always_comb begin
    x_wrap  = (x_q == XMax);
    y_wrap  = (y_q == YMax);
    x_d     = x_wrap ? '0 : x_q + 1'b1;
    y_d     = y_q;
    frame_d = frame_q;
    if (x_wrap) begin
      y_d = y_wrap ? '0 : y_q + 1'b1;
      if (y_wrap) begin
        frame_d = frame_q + 8'd1;
      end
    end
  end

  // Raster counter state
  always_ff @(posedge vclk or posedge reset) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= frame_d;
    end
  end

  // Coordinate decode, done at 32 bits so sync edges near 2**XW cannot alias
  always_comb begin
    x32         = 32'(x_q);
    y32         = 32'(y_q);
    active      = (x32 < HD) && (y32 < VD);
    hs_raw      = (x32 >= HsOn) && (x32 < HsOff);
    vs_raw      = (y32 >= VsOn) && (y32 < VsOff);
    line_start  = (x_q == '0);
    frame_start = (x_q == '0) && (y_q == '0);
`ifdef VGA_TIMING_TESTPAT_EN
    raw = {x32[8:6], active, vs_raw, hs_raw};
`else
    raw = {active, vs_raw, hs_raw};
`endif
  end

  assign posx      = x_q;
  assign posy      = y_q;
  assign frame_cnt = frame_q;

  // Delay line matching the renderer latency; LAT=0 feeds the output register directly
  if (LAT == 0) begin : g_nodly
    assign dly = raw;
  end else begin : g_dly
    logic [PW-1:0] pipe_q [LAT];

    // Shift raw timing through LAT blanked-at-reset stages
    always_ff @(posedge vclk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < int'(LAT); i++) begin
          pipe_q[i] <= '0;
        end
      end else begin
        pipe_q[0] <= raw;
        for (int i = 1; i < int'(LAT); i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign dly = pipe_q[LAT-1];
  end

  logic            hsync_q, hsync_d, vsync_q, vsync_d;
  logic [3*CW-1:0] rgb_q, rgb_d;

  // Output stage next-state: polarity-mapped sync and blank-masked colour
  always_comb begin
    hsync_d = dly[0] ? HPOL : ~HPOL;
    vsync_d = dly[1] ? VPOL : ~VPOL;
    rgb_d   = '0;
    if (dly[2]) begin
      rgb_d = rgb_in;
`ifdef VGA_TIMING_TESTPAT_EN
      if (test_en) begin
        rgb_d = {{CW{dly[5]}}, {CW{dly[4]}}, {CW{dly[3]}}};
      end
`endif
    end
  end

  // Output register, idle sync levels and black at reset
  always_ff @(posedge vclk or posedge reset) begin
    if (reset) begin
      hsync_q <= ~HPOL;
      vsync_q <= ~VPOL;
      rgb_q   <= '0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign red   = rgb_q[3*CW-1:2*CW];
  assign green = rgb_q[2*CW-1:CW];
  assign blue  = rgb_q[CW-1:0];

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator and output stage for the display path, clocked by the pixel clock `vclk`. It owns the horizontal and vertical counters and publishes pixel coordinates to the renderer (chessboard and result-line logic). It accepts the renderer's colour a fixed, parametrised number of cycles later and drives blank-masked RGB plus sync outputs that are delay-matched to that colour. It replaces hard-coded 640x480 timing with configurable geometry, sync polarity, colour depth and renderer latency.

## Interface
Parameters:
- `CW`, 1, colour bits per channel
- `XW`, 10, width of `posx` and the horizontal counter
- `YW`, 10, width of `posy` and the vertical counter
- `HD`, 640, visible pixels per line
- `HFP`, 16, horizontal front porch
- `HS`, 96, hsync pulse width
- `HBP`, 48, horizontal back porch
- `VD`, 480, visible lines
- `VFP`, 10, vertical front porch
- `VS`, 2, vsync pulse width
- `VBP`, 33, vertical back porch
- `HPOL`, 0, hsync level during the pulse (0 = active-low)
- `VPOL`, 0, vsync level during the pulse
- `LAT`, 1, renderer latency in cycles, from `posx`/`posy` to the matching `rgb_in`; legal range 0..15

Ports:
- `vclk`  in  1  pixel clock
- `reset`  in  1  asynchronous, active-high; clock `vclk`
- `rgb_in`  in  3*CW  renderer colour, ordered {R,G,B}
- `posx`  out  XW  current horizontal counter
- `posy`  out  YW  current vertical counter
- `active`  out  1  `posx<HD && posy<VD` (combinational from the counters)
- `line_start`  out  1  high while `posx==0`
- `frame_start`  out  1  high while `posx==0 && posy==0`
- `frame_cnt`  out  8  frame counter; wraps 255 to 0
- `hsync`, `vsync`  out  1  registered sync outputs
- `red`, `green`, `blue`  out  CW each  registered, blank-masked colour

## Operation
- HT = HD+HFP+HS+HBP (800 by default). VT = VD+VFP+VS+VBP (525 by default).
- Counter x counts 0..HT-1 and wraps to 0. When x wraps, y increments; y counts 0..VT-1 and wraps to 0.
- `frame_cnt` increments on the cycle where x and y both wrap to 0.
- Raw hsync is asserted for HD+HFP ≤ x < HD+HFP+HS (656..751 by default).
- Raw vsync is asserted for VD+VFP ≤ y < VD+VFP+VS (lines 490..491 by default). It covers whole lines.
- Delay pipeline: raw hsync, raw vsync and `active` are shifted through LAT stages, then one output register.
- Output register: `red/green/blue` = `rgb_in` when the delayed `active` is 1, otherwise 0.
- Output register: `hsync` = HPOL when the delayed raw hsync is 1, otherwise ~HPOL. `vsync` follows the same rule with VPOL.
- Counter arithmetic is unsigned and sized to XW/YW. HT-1 must fit in XW and VT-1 in YW; a misfit is a configuration error (elaboration-time check).
- Reset values:
  - x = 0, y = 0, `frame_cnt` = 0
  - all pipeline stages blanked: sync raw = 0, active = 0
  - `hsync` = ~HPOL, `vsync` = ~VPOL
  - colour outputs = 0
- Reset asserted mid-frame returns all of the above immediately (asynchronously). The raster restarts at (0,0) on the first `vclk` edge after release.

## Timing
- Counters advance every `vclk` edge; there is no enable.
- `posx`, `posy`, `active`, `line_start`, `frame_start` and `frame_cnt` reflect the counter state at cycle t.
- `rgb_in` sampled at cycle t+LAT must be the renderer's colour for the coordinates presented at cycle t.
- `hsync`, `vsync` and colour outputs change at edge t+LAT+1 for counter state t. Total output latency is LAT+1 cycles; sync and colour are mutually aligned.
- After reset release, the first LAT+1 cycles of output are blank with idle sync levels.
- LAT=0: `rgb_in` is combinational from `posx`/`posy` and is captured directly by the output register.

## Configuration
- Macro `VGA_TIMING_TESTPAT_EN`.
- Defined:
  - Adds input port `test_en` (1 bit).
  - The x bits [8:6] are carried through the same delay pipeline, giving bar index b.
  - While `test_en`=1, the output colour in the active area is R = {CW{b[2]}}, G = {CW{b[1]}}, B = {CW{b[0]}}. Bars are 64 px wide and the pattern repeats. `rgb_in` is ignored.
  - Blanking and sync behave as normal.
  - `test_en` is sampled at the output register.
- Undefined: `test_en` does not exist and colour is always `rgb_in`, masked as above.

## Test plan
- Defaults, LAT=1, reset pulse mid-line: all outputs take reset values immediately. After release, `posx` = 0,1,2…, `hsync` stays 1 for the first 2 cycles, and `vsync` stays 1.
- Defaults, LAT=1, run one line: `hsync` goes 0 exactly 658 cycles after x=0 and stays low for 96 cycles. `line_start` period = 800 cycles.
- Defaults, run 2 frames: `vsync` is low for 1600 cycles starting at line 490 (plus 2-cycle skew). `frame_start` pulses every 420000 cycles. `frame_cnt` reads 0, then 1, then 2.
- LAT=3, `rgb_in` = 3'b101 constant:
  - `red`=1, `blue`=1 first appear 4 cycles after `active` rises.
  - Outputs are 0 for x ≥ 640 (delayed) and for every line with y ≥ 480.
- HPOL=1, VPOL=1, HD=8, HFP=1, HS=2, HBP=1, VD=4, VFP=1, VS=1, VBP=1:
  - HT=12, VT=7.
  - `hsync` is high for 2 of every 12 cycles; `vsync` is high for 12 cycles per 84-cycle frame.
  - Reset levels are 0.
- `VGA_TIMING_TESTPAT_EN`, `test_en`=1, defaults: x=0..63 → black, x=64..127 → blue, x=448..511 → white, x=512..575 → black again. Blanking region outputs 0.
